parser_packet_scheduler: RTL and testbench

//  Sequencing FSM for the header buffer/parser/dispatcher stage. Drives the shared state/count bus, gates

---
 rtl/parser_packet_scheduler_if.sv | 12 +
 rtl/parser_packet_scheduler.sv | 173 +++++++++++++++++
 tb/tb_parser_packet_scheduler.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/parser_packet_scheduler_if.sv
// rtl/parser_packet_scheduler_if.sv - AXIS handshake bundle (valid/ready/last/keep) for the packet scheduler
interface parser_packet_scheduler_if #(
    parameter int KEEP_WIDTH = 8
);
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;
    logic [KEEP_WIDTH-1:0] tkeep;

    modport master (output tvalid, output tlast, output tkeep, input tready);
    modport slave  (input tvalid, input tlast, input tkeep, output tready);
endinterface

// File: rtl/parser_packet_scheduler.sv
// rtl/parser_packet_scheduler.sv - sequencing FSM for header buffer / parser / dispatcher stage
module parser_packet_scheduler #(
    parameter int COUNT_META_DATA_MAX = 5,
    parameter int COUNTER_WIDTH       = $clog2(COUNT_META_DATA_MAX + 1),
    parameter int STATE_WIDTH         = 3,
    parameter int AXIS_KEEP_WIDTH     = 8,
    parameter int CONTROL_TIMEOUT     = 16,
    parameter int STAT_WIDTH          = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    parser_packet_scheduler_if.slave  s_axis,
    parser_packet_scheduler_if.master m_axis,
    output logic                     bypass,
    output logic [STATE_WIDTH-1:0]   state,
    output logic [COUNTER_WIDTH-1:0] count,
    input  logic                     verdict_valid,
    input  logic                     verdict_drop,
    output logic [STAT_WIDTH-1:0]    stat_fwd,
    output logic [STAT_WIDTH-1:0]    stat_drop
);
    localparam int TIMER_WIDTH = $clog2(CONTROL_TIMEOUT + 1);

    typedef enum logic [STATE_WIDTH-1:0] {
        ST_IDLE          = STATE_WIDTH'(0),
        ST_PARSE_DATA    = STATE_WIDTH'(1),
        ST_CONTROL       = STATE_WIDTH'(2),
        ST_SEND_ANALYSED = STATE_WIDTH'(3),
        ST_SEND_REMAIN   = STATE_WIDTH'(4),
        ST_DROP          = STATE_WIDTH'(5)
    } state_t;

    state_t                     state_q;
    state_t                     state_d;
    logic [COUNTER_WIDTH-1:0]   cnt_q;
    logic [COUNTER_WIDTH-1:0]   hdr_beats;
    logic                       tlast_seen;
    logic [AXIS_KEEP_WIDTH-1:0] last_keep;
    logic [TIMER_WIDTH-1:0]     timer;
    logic                       primed;
    logic [STAT_WIDTH-1:0]      fwd_q;
    logic [STAT_WIDTH-1:0]      drop_q;

    // Handshake terms derived from inputs and registers only, so the output
    // process never has to read back the ports it drives.
    logic parse_last;
    logic last_hdr;
    logic hdr_fire;
    logic remain_end;
    logic drop_end;

    assign parse_last = s_axis.tlast || (cnt_q == COUNTER_WIDTH'(COUNT_META_DATA_MAX - 1));
    assign last_hdr   = (cnt_q == hdr_beats - 1'b1);
    assign hdr_fire   = primed & m_axis.tready;
    assign remain_end = s_axis.tvalid & m_axis.tready & s_axis.tlast;
    assign drop_end   = tlast_seen | (s_axis.tvalid & s_axis.tlast);

    assign state     = state_q;
    assign stat_fwd  = fwd_q;
    assign stat_drop = drop_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decision
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:          if (s_axis.tvalid) state_d = ST_PARSE_DATA;
            ST_PARSE_DATA:    if (s_axis.tvalid && parse_last) state_d = ST_CONTROL;
            ST_CONTROL: begin
                if (verdict_valid) begin
                    state_d = verdict_drop ? ST_DROP : ST_SEND_ANALYSED;
                end else if (timer == TIMER_WIDTH'(CONTROL_TIMEOUT - 1)) begin
                    state_d = ST_DROP;
                end
            end
            ST_SEND_ANALYSED: if (hdr_fire && last_hdr) state_d = tlast_seen ? ST_IDLE : ST_SEND_REMAIN;
            ST_SEND_REMAIN:   if (remain_end) state_d = ST_IDLE;
            ST_DROP:          if (drop_end) state_d = ST_IDLE;
            default:          state_d = ST_IDLE;
        endcase
    end

    // Handshake gating, bypass select and the look-ahead beat index
    always_comb begin
        s_axis.tready = 1'b0;
        m_axis.tvalid = 1'b0;
        m_axis.tlast  = 1'b0;
        m_axis.tkeep  = '0;
        bypass        = 1'b0;
        count         = cnt_q;
        case (state_q)
            ST_PARSE_DATA: s_axis.tready = 1'b1;
            ST_SEND_ANALYSED: begin
                m_axis.tvalid = primed;
                if (primed) begin
                    m_axis.tlast = tlast_seen & last_hdr;
                    m_axis.tkeep = (tlast_seen && last_hdr) ? last_keep : '1;
                end
                // Buffer output register reloads every cycle; advance only on accept.
                count = cnt_q + COUNTER_WIDTH'(hdr_fire);
            end
            ST_SEND_REMAIN: begin
                bypass        = 1'b1;
                m_axis.tvalid = s_axis.tvalid;
                s_axis.tready = m_axis.tready;
                m_axis.tlast  = s_axis.tlast;
                m_axis.tkeep  = s_axis.tkeep;
            end
            ST_DROP: s_axis.tready = ~tlast_seen;
            default: ;
        endcase
    end

    // Beat counter, header bookkeeping, verdict timer and statistics
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            hdr_beats  <= '0;
            tlast_seen <= 1'b0;
            last_keep  <= '0;
            timer      <= '0;
            primed     <= 1'b0;
            fwd_q      <= '0;
            drop_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_q      <= '0;
                    hdr_beats  <= '0;
                    tlast_seen <= 1'b0;
                    timer      <= '0;
                    primed     <= 1'b0;
                end
                ST_PARSE_DATA: begin
                    timer <= '0;
                    if (s_axis.tvalid) begin
                        cnt_q      <= parse_last ? '0 : cnt_q + 1'b1;
                        hdr_beats  <= cnt_q + 1'b1;
                        last_keep  <= s_axis.tkeep;
                        tlast_seen <= s_axis.tlast;
                    end
                end
                ST_CONTROL: begin
                    cnt_q  <= '0;
                    primed <= 1'b0;
                    timer  <= timer + 1'b1;
                end
                ST_SEND_ANALYSED: begin
                    primed <= 1'b1;
                    if (hdr_fire) begin
                        cnt_q <= last_hdr ? '0 : cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase

            if ((state_q == ST_SEND_ANALYSED || state_q == ST_SEND_REMAIN) && state_d == ST_IDLE) begin
                fwd_q <= fwd_q + 1'b1;
            end
            if (state_q == ST_DROP && state_d == ST_IDLE) begin
                drop_q <= drop_q + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_parser_packet_scheduler.sv
// tb/tb_parser_packet_scheduler.sv - directed self-checking bench for parser_packet_scheduler
module tb_parser_packet_scheduler;
    localparam int MAX = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic        bypass;
    logic [2:0]  state;
    logic [2:0]  count;
    logic        verdict_valid;
    logic        verdict_drop;
    logic [31:0] stat_fwd;
    logic [31:0] stat_drop;

    parser_packet_scheduler_if #(.KEEP_WIDTH(8)) s_axis ();
    parser_packet_scheduler_if #(.KEEP_WIDTH(8)) m_axis ();

    parser_packet_scheduler dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis        (s_axis),
        .m_axis        (m_axis),
        .bypass        (bypass),
        .state         (state),
        .count         (count),
        .verdict_valid (verdict_valid),
        .verdict_drop  (verdict_drop),
        .stat_fwd      (stat_fwd),
        .stat_drop     (stat_drop)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Buffer model and egress log
    int in_id;
    int bufm [MAX];
    int out_reg;
    int eg_id[$];
    int eg_last[$];
    int eg_keep[$];
    int eg_byp[$];
    int eg_cyc[$];
    int cyc;
    int ctrl_cycles;
    int drop_acc;
    int mvalid_bad;
    int parse_count_bad;
    int stall_bad;
    int stall_cnt;
    int stall_pending;
    int stall_val;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic clear_logs();
        eg_id.delete(); eg_last.delete(); eg_keep.delete(); eg_byp.delete(); eg_cyc.delete();
        ctrl_cycles = 0; drop_acc = 0; mvalid_bad = 0; parse_count_bad = 0;
        stall_bad = 0; stall_cnt = 0; stall_pending = 0;
    endtask

    // Sample mid-cycle: inputs change 1ns after posedge, so this sees the values the next edge acts on
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            if (stall_pending != 0 && m_axis.tvalid && state == 3'd3 && out_reg != stall_val) stall_bad++;
            stall_pending = 0;
            if (state == 3'd1 && count >= 3'(MAX)) parse_count_bad++;
            if (state == 3'd1 && s_axis.tvalid && s_axis.tready && count < 3'(MAX)) bufm[int'(count)] = in_id;
            if (state == 3'd2) ctrl_cycles++;
            if (state == 3'd5 && s_axis.tvalid && s_axis.tready) drop_acc++;
            if (m_axis.tvalid && state != 3'd3 && state != 3'd4) mvalid_bad++;
            if (m_axis.tvalid && m_axis.tready) begin
                eg_id.push_back(bypass ? in_id : out_reg);
                eg_last.push_back(int'(m_axis.tlast));
                eg_keep.push_back(int'(m_axis.tkeep));
                eg_byp.push_back(int'(bypass));
                eg_cyc.push_back(cyc);
            end
            if (m_axis.tvalid && !m_axis.tready && state == 3'd3) begin
                stall_pending = 1; stall_val = out_reg; stall_cnt++;
            end
            if (state == 3'd3 && count < 3'(MAX)) out_reg = bufm[int'(count)];
        end
    end

    task automatic send_pkt(input int n, input logic [7:0] lkeep);
        for (int i = 0; i < n; i++) begin
            int t = 0;
            bit fired = 0;
            in_id = i;
            s_axis.tvalid = 1'b1;
            s_axis.tlast  = (i == n - 1);
            s_axis.tkeep  = (i == n - 1) ? lkeep : 8'hFF;
            while (!fired && t < 300) begin
                @(negedge clk);
                fired = s_axis.tready;
                @(posedge clk); #1;
                t++;
            end
            if (!fired) check($sformatf("ingress_timeout_beat%0d", i), 0, 1);
        end
        s_axis.tvalid = 1'b0;
        s_axis.tlast  = 1'b0;
        s_axis.tkeep  = 8'h00;
    endtask

    task automatic give_verdict(input int delay, input bit drop);
        int t = 0;
        while (state != 3'd2 && t < 300) begin @(posedge clk); #1; t++; end
        if (t >= 300) check("verdict_wait_control", state, 2);
        repeat (delay) begin @(posedge clk); #1; end
        verdict_valid = 1'b1;
        verdict_drop  = drop;
        @(posedge clk); #1;
        verdict_valid = 1'b0;
        verdict_drop  = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while (state != 3'd0 && t < 300) begin @(posedge clk); #1; t++; end
        if (t >= 300) check("wait_idle_timeout", state, 0);
        repeat (2) begin @(posedge clk); #1; end
    endtask

    task automatic toggle_ready(input int n);
        repeat (n) begin
            m_axis.tready = ~m_axis.tready;
            @(posedge clk); #1;
        end
        m_axis.tready = 1'b1;
    endtask

    task automatic check_seq(input string tag, input int n, input int base, input int nhdr,
                             input logic [7:0] lkeep, input bit contig);
        check({tag, "_beats"}, eg_id.size(), n);
        if (eg_id.size() == n) begin
            for (int i = 0; i < n; i++) begin
                check($sformatf("%s_id%0d", tag, i),   eg_id[i],   base + i);
                check($sformatf("%s_last%0d", tag, i), eg_last[i], (i == n - 1) ? 1 : 0);
                check($sformatf("%s_keep%0d", tag, i), eg_keep[i], (i == n - 1) ? lkeep : 8'hFF);
                check($sformatf("%s_byp%0d", tag, i),  eg_byp[i],  (i >= nhdr) ? 1 : 0);
            end
            if (contig) check({tag, "_gap"}, eg_cyc[n - 1] - eg_cyc[0], n - 1);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        s_axis.tvalid = 1'b0; s_axis.tlast = 1'b0; s_axis.tkeep = 8'h00;
        m_axis.tready = 1'b1;
        verdict_valid = 1'b0; verdict_drop = 1'b0;
        in_id = 0; out_reg = 0; cyc = 0;
        clear_logs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_state",  state, 0);
        check("rst_count",  count, 0);
        check("rst_sready", s_axis.tready, 0);
        check("rst_mvalid", m_axis.tvalid, 0);
        check("rst_mlast",  m_axis.tlast, 0);
        check("rst_bypass", bypass, 0);
        check("rst_fwd",    stat_fwd, 0);
        check("rst_drop",   stat_drop, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // 3-beat packet, forward after 2 CONTROL cycles
        clear_logs();
        fork
            send_pkt(3, 8'h0F);
            give_verdict(2, 1'b0);
        join
        wait_idle();
        check_seq("t1", 3, 0, 3, 8'h0F, 1'b1);
        check("t1_fwd", stat_fwd, 1);
        check("t1_mvalid_outside", mvalid_bad, 0);

        // 8-beat packet, forward: 5 buffered beats then 3 bypassed
        clear_logs();
        fork
            send_pkt(8, 8'h03);
            give_verdict(1, 1'b0);
        join
        wait_idle();
        check_seq("t2", 8, 0, 5, 8'h03, 1'b1);
        check("t2_fwd", stat_fwd, 2);
        check("t2_parse_count", parse_count_bad, 0);

        // 8-beat packet, dropped: remainder drained
        clear_logs();
        fork
            send_pkt(8, 8'hFF);
            give_verdict(0, 1'b1);
        join
        wait_idle();
        check("t3_beats", eg_id.size(), 0);
        check("t3_drained", drop_acc, 3);
        check("t3_drop", stat_drop, 1);
        check("t3_fwd", stat_fwd, 2);
        check("t3_state", state, 0);
        check("t3_mvalid_outside", mvalid_bad, 0);

        // No verdict within the window: forced drop, late verdict ignored
        clear_logs();
        fork
            send_pkt(2, 8'h07);
            give_verdict(20, 1'b0);
        join
        wait_idle();
        check("t4_ctrl_cycles", ctrl_cycles, 16);
        check("t4_beats", eg_id.size(), 0);
        check("t4_drop", stat_drop, 2);
        check("t4_fwd", stat_fwd, 2);
        check("t4_state", state, 0);

        // Egress ready toggling during header replay
        clear_logs();
        fork
            send_pkt(4, 8'h01);
            give_verdict(1, 1'b0);
            toggle_ready(60);
        join
        wait_idle();
        check_seq("t5", 4, 0, 4, 8'h01, 1'b0);
        check("t5_stalled", stall_cnt > 0, 1);
        check("t5_stable", stall_bad, 0);
        check("t5_fwd", stat_fwd, 3);

        // Reset while streaming the remainder; leftover beats form a new packet
        clear_logs();
        fork
            send_pkt(8, 8'h3F);
            give_verdict(0, 1'b0);
            begin
                int t = 0;
                while (state != 3'd4 && t < 300) begin @(posedge clk); #1; t++; end
                check("t6_reached_remain", state, 4);
                m_axis.tready = 1'b0;
                rst = 1'b1;
                @(posedge clk);
                @(negedge clk);
                check("t6_rst_state",  state, 0);
                check("t6_rst_count",  count, 0);
                check("t6_rst_mvalid", m_axis.tvalid, 0);
                check("t6_rst_sready", s_axis.tready, 0);
                check("t6_rst_bypass", bypass, 0);
                check("t6_rst_fwd",    stat_fwd, 0);
                check("t6_rst_drop",   stat_drop, 0);
                @(posedge clk); #1;
                rst = 1'b0;
                clear_logs();
                m_axis.tready = 1'b1;
                give_verdict(1, 1'b0);
            end
        join
        wait_idle();
        check_seq("t6", 3, 5, 3, 8'h3F, 1'b1);
        check("t6_fwd", stat_fwd, 1);
        check("t6_drop", stat_drop, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
